// File: rtl/seven_seg_scan_controller_if.sv
// ============================================================================
// Module   : seven_seg_scan_controller_if
// Brief    : Host write channel into the seven-segment scan controller.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface seven_seg_scan_controller_if;
    logic       wrValid;
    logic       wrReady;
    logic [2:0] wrAddr;
    logic [3:0] wrData;
    logic       wrBlank;

    modport master (output wrValid, wrAddr, wrData, wrBlank, input wrReady);
    modport slave  (input wrValid, wrAddr, wrData, wrBlank, output wrReady);
endinterface

`default_nettype wire

// File: rtl/seven_seg_scan_controller.sv
// ============================================================================
// Module   : seven_seg_scan_controller
// Brief    : Multiplexed common-anode seven-segment scanner with double-buffered
//            digits, guard intervals, blanking and leading-zero suppression.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module seven_seg_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  wire                         clk,
    input  wire                         resetn,
    seven_seg_scan_controller_if.slave  wr,
    input  wire                         lzsEn,
    output logic [3:0]                  nOut,
    input  wire  [6:0]                  segIn,
    output logic [6:0]                  ssOut,
    output logic [NUM_DIGITS-1:0]       digitSel,
    output logic                        frameDone
);

    localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_BLANK  = 2'd0,
        S_DRIVE  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t                       r_state;
    state_t                       w_nextState;
    logic [c_IDX_W-1:0]           r_index;
    logic [c_IDX_W-1:0]           w_nextIndex;
    logic [CNT_W-1:0]             r_cnt;
    logic [CNT_W-1:0]             w_nextCnt;
    logic                         w_commit;
    logic [NUM_DIGITS-1:0]        w_nextDigitSel;
    logic                         w_nextFrameDone;

    logic [NUM_DIGITS-1:0][3:0]   r_activeNib;
    logic [NUM_DIGITS-1:0]        r_activeBlk;
    logic [NUM_DIGITS-1:0][3:0]   r_shadowNib;
    logic [NUM_DIGITS-1:0]        r_shadowBlk;
    logic [6:0]                   r_ssOut;
    logic [NUM_DIGITS-1:0]        r_digitSel;
    logic                         r_frameDone;

    logic                         w_wrFire;
    logic                         w_zeroRun;
    logic [NUM_DIGITS-1:0]        w_effBlank;

    assign wr.wrReady = (r_state != S_COMMIT);
    assign w_wrFire   = wr.wrValid && wr.wrReady;

    assign nOut      = r_activeNib[r_index];
    assign ssOut     = r_ssOut;
    assign digitSel  = r_digitSel;
    assign frameDone = r_frameDone;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_BLANK;
            r_index     <= '0;
            r_cnt       <= '0;
            r_digitSel  <= '1;
            r_frameDone <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_index     <= w_nextIndex;
            r_cnt       <= w_nextCnt;
            r_digitSel  <= w_nextDigitSel;
            r_frameDone <= w_nextFrameDone;
        end
    end

    // Pin registers are loaded from the next state so they line up with r_state.
    always_comb begin
        w_nextState = r_state;
        w_nextIndex = r_index;
        w_nextCnt   = r_cnt + 1'b1;
        w_commit    = 1'b0;
        case (r_state)
            S_BLANK: begin
                if (r_cnt == CNT_W'(GUARD_CYCLES - 1)) begin
                    w_nextState = S_DRIVE;
                    w_nextCnt   = '0;
                end
            end
            S_DRIVE: begin
                if (r_cnt == CNT_W'(REFRESH_DIV - 1)) begin
                    w_nextCnt = '0;
                    if (r_index == c_LAST_IDX) begin
                        w_nextState = S_COMMIT;
                    end else begin
                        w_nextIndex = r_index + 1'b1;
                        w_nextState = S_BLANK;
                    end
                end
            end
            S_COMMIT: begin
                w_commit    = 1'b1;
                w_nextState = S_BLANK;
                w_nextIndex = '0;
                w_nextCnt   = '0;
            end
            default: begin
                w_nextState = S_BLANK;
                w_nextIndex = '0;
                w_nextCnt   = '0;
            end
        endcase

        w_nextDigitSel = '1;
        if (w_nextState == S_DRIVE) begin
            w_nextDigitSel[w_nextIndex] = 1'b0;
        end
        w_nextFrameDone = (w_nextState == S_COMMIT);
    end

    // Host writes never coincide with the commit copy because wrReady is low then.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_shadowNib <= '0;
            r_shadowBlk <= '1;
            r_activeNib <= '0;
            r_activeBlk <= '1;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_wrFire && (wr.wrAddr == 3'(i))) begin
                    r_shadowNib[i] <= wr.wrData;
                    r_shadowBlk[i] <= wr.wrBlank;
                end
            end
            if (w_commit) begin
                r_activeNib <= r_shadowNib;
                r_activeBlk <= r_shadowBlk;
            end
        end
    end

    // A digit is a leading zero while every digit from the top down to it is a visible 0.
    always_comb begin
        w_zeroRun  = 1'b1;
        w_effBlank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zeroRun     = w_zeroRun && (r_activeNib[i] == 4'h0) && !r_activeBlk[i];
            w_effBlank[i] = r_activeBlk[i] || (lzsEn && (i != 0) && w_zeroRun);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ssOut <= 7'h7F;
        end else begin
            r_ssOut <= w_effBlank[r_index] ? 7'h7F : segIn;
        end
    end

endmodule

`default_nettype wire

// File: doc/seven_seg_scan_controller.md
Name: seven_seg_scan_controller

Overview:
- Time-multiplexes one shared hex-to-seven-segment decoder across NUM_DIGITS common-anode digits.
- Holds double-buffered digit values: host writes land in a shadow bank, which is copied to the active bank once per frame to prevent tearing.
- Sequences digit select with anti-ghosting guard intervals and applies per-digit blanking and optional leading-zero suppression.
- Sits between the host/datapath and the board's segment and anode pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
REFRESH_DIV, 50000, cycles each digit is driven per frame (>=2)
GUARD_CYCLES, 4, cycles all anodes are off before each digit (>=2)
CNT_W, 16, dwell counter width; must hold max(REFRESH_DIV, GUARD_CYCLES)

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
wrValid  input  1  host write request
wrReady  output  1  controller can accept a write
wrAddr  input  3  digit index; 0 = rightmost
wrData  input  4  hex nibble for the digit
wrBlank  input  1  1 = blank this digit
lzsEn  input  1  leading-zero suppression enable (live, not buffered)
nOut  output  4  nibble to the shared decoder
segIn  input  7  decoder result, active-low {g..a}
ssOut  output  7  registered segment pins, active-low
digitSel  output  NUM_DIGITS  anode enables, active-low one-hot
frameDone  output  1  one-cycle pulse in the COMMIT cycle

Behaviour:
- Reset (async, resetn=0):
  - active and shadow nibbles = 0; active and shadow blank bits = 1 (display dark).
  - state = BLANK, digit index = 0, counter = 0.
  - nOut = 0, ssOut = 7'h7F, digitSel = all 1s, frameDone = 0, wrReady = 1.
  - Reset asserted mid-frame aborts the frame. Any shadow writes not yet committed are lost.
- Write handshake: a write transfers on a clk edge with wrValid && wrReady.
  - shadow[wrAddr] <= {wrBlank, wrData}.
  - wrAddr >= NUM_DIGITS: the write is accepted and discarded.
  - wrReady = 0 only in the COMMIT state; otherwise 1.
  - A stalled write must hold its inputs until accepted.
  - Repeated writes to one address within a frame: the last one wins.
- FSM:
  - BLANK: all anodes off; nOut = active nibble of the current digit. Stay GUARD_CYCLES cycles, then go to DRIVE.
  - DRIVE: digitSel bit [index] = 0, others 1. Stay REFRESH_DIV cycles.
    - If index = NUM_DIGITS-1: go to COMMIT.
    - Otherwise: index+1, go to BLANK.
  - COMMIT: exactly 1 cycle. Active bank <= shadow bank; frameDone = 1; anodes off; index <= 0; go to BLANK.
  - The counter resets on every state entry.
  - Frame length = NUM_DIGITS*(GUARD_CYCLES+REFRESH_DIV)+1 cycles.
- Segment path:
  - ssOut <= segIn every cycle (one-cycle latency).
  - If the effective blank for the current digit = 1, ssOut <= 7'h7F instead.
  - Because GUARD_CYCLES >= 2, ssOut is stable before the anode enables.
- Effective blank = active blank bit OR LZS-blank. LZS-blank is true for digit i when all of these hold:
  - lzsEn = 1;
  - i != 0;
  - every active digit from NUM_DIGITS-1 down to i has nibble 0 and blank bit 0.
  - Digit 0 is never LZS-blanked.
- digitSel and frameDone are registered (glitch-free at the pins). At most one digitSel bit is 0 in any cycle.
- A write in the same cycle as the last DRIVE cycle is accepted and is included in the COMMIT that follows.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=2, frame = 25 cycles):
- Reset then run 1 frame with no writes -> ssOut = 7'h7F throughout; digitSel walks 1110, 1101, 1011, 0111, each low for exactly 4 cycles with 2 all-1s cycles between; frameDone pulses once at cycle 25.
- Write {0,4'h3} to addr 0 mid-frame -> no change until COMMIT; in the next frame, during digit 0 drive, nOut = 3 and ssOut = 7'b0110000 (decoder model).
- Write digits 3..0 = 0,0,7,1 (blank = 0), lzsEn = 1 -> digits 3 and 2 show 7'h7F; digit 1 shows 7'b1111000. With lzsEn = 0 -> digits 3 and 2 show 7'b1000000.
- Hold wrValid = 1 across COMMIT -> wrReady = 0 for exactly that cycle; the write completes the next cycle and appears one frame later. A write on the last DRIVE cycle appears in the immediately following frame.
- Write to addr 5 -> wrReady = 1, transfer occurs, display unchanged after COMMIT.
- Pull resetn low during digit 2 drive -> digitSel = 1111, ssOut = 7'h7F immediately; after release the scan restarts at digit 0 with blanked digits.
